// File: rtl/motor_pkg.sv
// Shared types and constants for the two-wheel motor driver.
package motor_pkg;

  typedef enum logic [1:0] {
    PARADO  = 2'd0,
    ANDANDO = 2'd1,
    GIRANDO = 2'd2,
    FREANDO = 2'd3
  } state_t;

  // {Front, Rotate} as registered from the controller
  localparam logic [1:0] CMD_STOP = 2'b00;
  localparam logic [1:0] CMD_ROT  = 2'b01;
  localparam logic [1:0] CMD_FWD  = 2'b10;
  localparam logic [1:0] CMD_BOTH = 2'b11;

  localparam logic DIR_FWD = 1'b1;
  localparam logic DIR_REV = 1'b0;

endpackage

// File: rtl/motor_pwm_channel.sv
// One wheel's PWM output: registered compare of the next counter value against the next duty,
// so the output during a cycle equals (cnt < duty) for that cycle.
module motor_pwm_channel #(
  parameter int DW = 7
) (
  input  logic          Clock,
  input  logic          Reset,
  input  logic [DW-1:0] cnt_next,
  input  logic [DW-1:0] duty_next,
  output logic          pwm
);

  // PWM output register; asynchronous reset drops the enable immediately
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      pwm <= 1'b0;
    end else begin
      pwm <= (cnt_next < duty_next);
    end
  end

endmodule

// File: rtl/motor_driver.sv
// Two-wheel motor driver: duty ramp with a brake phase before any direction reversal.
// Ramping is enabled by defining MOTOR_DRIVER_RAMP_EN; otherwise duty jumps to its target at each wrap.
module motor_driver
  import motor_pkg::*;
#(
  parameter int PWM_PERIOD = 100,
  parameter int DUTY_MAX   = 80,
  parameter int ROT_DUTY   = 50,
  parameter int RAMP_STEP  = 5
) (
  input  logic Clock,
  input  logic Reset,
  input  logic Front,
  input  logic Rotate,
  output logic LeftPwm,
  output logic RightPwm,
  output logic LeftDir,
  output logic RightDir,
  output logic Busy,
  output logic Fault
);

  localparam int DW = $clog2(PWM_PERIOD + 1);
`ifdef MOTOR_DRIVER_RAMP_EN
  localparam bit RAMP_EN = 1'b1;
`else
  localparam bit RAMP_EN = 1'b0;
`endif
  // A step as large as the whole period makes every move land on its target in one wrap
  localparam int            STEP_I = RAMP_EN ? RAMP_STEP : PWM_PERIOD;
  localparam logic [DW-1:0] STEP   = DW'(STEP_I);
  localparam logic [DW-1:0] DMAX   = DW'(DUTY_MAX);
  localparam logic [DW-1:0] DROT   = DW'(ROT_DUTY);
  localparam logic [DW-1:0] LAST   = DW'(PWM_PERIOD - 1);
  localparam logic [DW-1:0] ZERO   = {DW{1'b0}};

  // Move cur one step toward target, saturating at the target
  function automatic logic [DW-1:0] toward(input logic [DW-1:0] cur, input logic [DW-1:0] target);
    logic [DW:0] sum;
    sum = {1'b0, cur} + {1'b0, STEP};
    if (cur < target) begin
      toward = (sum > {1'b0, target}) ? target : sum[DW-1:0];
    end else if ((cur - target) > STEP) begin
      toward = cur - STEP;
    end else begin
      toward = target;
    end
  endfunction

  logic          front_r, rotate_r, fault_r, busy_r;
  logic          left_dir_r, right_dir_r, left_dir_next_s, right_dir_next_s;
  logic          start_ldir_s, start_rdir_s, wrap_s;
  logic [1:0]    cmd_s;
  logic [DW-1:0] cnt_r, cnt_next_s, duty_r, duty_next_s, start_duty_s;
  state_t        state_r, state_next_s, start_state_s;

  assign cmd_s      = {front_r, rotate_r};
  assign wrap_s     = (cnt_r == LAST);
  assign cnt_next_s = wrap_s ? ZERO : cnt_r + DW'(1);

  // Input register, period counter and fault flag
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      front_r  <= 1'b0;
      rotate_r <= 1'b0;
      fault_r  <= 1'b0;
      cnt_r    <= ZERO;
    end else begin
      front_r  <= Front;
      rotate_r <= Rotate;
      fault_r  <= (cmd_s == CMD_BOTH);
      cnt_r    <= cnt_next_s;
    end
  end

  // Motion started from rest for the current command, including its first ramp step
  always_comb begin
    start_state_s = PARADO;
    start_duty_s  = ZERO;
    start_ldir_s  = left_dir_r;
    start_rdir_s  = right_dir_r;
    case (cmd_s)
      CMD_FWD: begin
        start_state_s = ANDANDO;
        start_duty_s  = toward(ZERO, DMAX);
        start_ldir_s  = DIR_FWD;
        start_rdir_s  = DIR_FWD;
      end
      CMD_ROT: begin
        start_state_s = GIRANDO;
        start_duty_s  = toward(ZERO, DROT);
        start_ldir_s  = DIR_FWD;
        start_rdir_s  = DIR_REV;
      end
      CMD_STOP: begin
        start_state_s = PARADO;
      end
      default: begin
        start_state_s = PARADO;
      end
    endcase
  end

  // Next state, duty and directions; everything holds except at the wrap
  always_comb begin
    state_next_s     = state_r;
    duty_next_s      = duty_r;
    left_dir_next_s  = left_dir_r;
    right_dir_next_s = right_dir_r;
    if (wrap_s) begin
      case (state_r)
        PARADO: begin
          state_next_s     = start_state_s;
          duty_next_s      = start_duty_s;
          left_dir_next_s  = start_ldir_s;
          right_dir_next_s = start_rdir_s;
        end
        ANDANDO: begin
          if (cmd_s == CMD_FWD) begin
            duty_next_s = toward(duty_r, DMAX);
          end else begin
            state_next_s = FREANDO;
            duty_next_s  = toward(duty_r, ZERO);
          end
        end
        GIRANDO: begin
          if (cmd_s == CMD_ROT) begin
            duty_next_s = toward(duty_r, DROT);
          end else begin
            state_next_s = FREANDO;
            duty_next_s  = toward(duty_r, ZERO);
          end
        end
        FREANDO: begin
          // The brake always runs to zero; only then is the command looked at again
          if (duty_r != ZERO) begin
            duty_next_s = toward(duty_r, ZERO);
          end else begin
            state_next_s     = start_state_s;
            duty_next_s      = start_duty_s;
            left_dir_next_s  = start_ldir_s;
            right_dir_next_s = start_rdir_s;
          end
        end
        default: begin
          state_next_s = PARADO;
          duty_next_s  = ZERO;
        end
      endcase
    end else begin
      state_next_s = state_r;
    end
  end

  // FSM state, shared duty, wheel directions and busy flag
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_r     <= PARADO;
      duty_r      <= ZERO;
      left_dir_r  <= DIR_FWD;
      right_dir_r <= DIR_FWD;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_next_s;
      duty_r      <= duty_next_s;
      left_dir_r  <= left_dir_next_s;
      right_dir_r <= right_dir_next_s;
      busy_r      <= (state_next_s == FREANDO);
    end
  end

  motor_pwm_channel #(.DW(DW)) u_left (
    .Clock    (Clock),
    .Reset    (Reset),
    .cnt_next (cnt_next_s),
    .duty_next(duty_next_s),
    .pwm      (LeftPwm)
  );

  motor_pwm_channel #(.DW(DW)) u_right (
    .Clock    (Clock),
    .Reset    (Reset),
    .cnt_next (cnt_next_s),
    .duty_next(duty_next_s),
    .pwm      (RightPwm)
  );

  assign LeftDir  = left_dir_r;
  assign RightDir = right_dir_r;
  assign Busy     = busy_r;
  assign Fault    = fault_r;

endmodule

// File: tb/tb_motor_driver.sv
// Bench for motor_driver: per-period vector table, async reset check and random commands
// checked cycle by cycle against a period-level reference model.
module tb_motor_driver;

  localparam int PER = 10;
  localparam int DMX = 8;
  localparam int DRT = 4;
`ifdef MOTOR_DRIVER_RAMP_EN
  localparam bit RAMP = 1'b1;
`else
  localparam bit RAMP = 1'b0;
`endif
  localparam int STEP = RAMP ? 4 : PER;

  logic Clock, Reset, Front, Rotate;
  logic LeftPwm, RightPwm, LeftDir, RightDir, Busy, Fault;

  int total = 0;
  int bad   = 0;

  // reference model: duty, wheel directions, braking flag, command pipeline
  int       m_cnt, m_duty;
  bit       m_ldir, m_rdir, m_brake, m_fault;
  bit [1:0] m_cmd;

  motor_driver #(
    .PWM_PERIOD(PER), .DUTY_MAX(DMX), .ROT_DUTY(DRT), .RAMP_STEP(4)
  ) dut (
    .Clock(Clock), .Reset(Reset), .Front(Front), .Rotate(Rotate),
    .LeftPwm(LeftPwm), .RightPwm(RightPwm), .LeftDir(LeftDir), .RightDir(RightDir),
    .Busy(Busy), .Fault(Fault)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_duty = 0; m_ldir = 1'b1; m_rdir = 1'b1;
    m_brake = 1'b0; m_fault = 1'b0; m_cmd = 2'b00;
  endtask

  task automatic model_start();
    if (m_cmd == 2'b10) begin
      m_ldir = 1'b1; m_rdir = 1'b1; m_duty = (STEP < DMX) ? STEP : DMX;
    end else if (m_cmd == 2'b01) begin
      m_ldir = 1'b1; m_rdir = 1'b0; m_duty = (STEP < DRT) ? STEP : DRT;
    end
  endtask

  // Once per period: keep going the same way, brake before any change, or start from rest
  task automatic model_wrap();
    bit same;
    int tgt;
    same = (m_cmd == 2'b10 && m_rdir) || (m_cmd == 2'b01 && !m_rdir);
    tgt  = (m_cmd == 2'b10) ? DMX : DRT;
    if (m_brake) begin
      if (m_duty > 0) m_duty = (m_duty > STEP) ? m_duty - STEP : 0;
      else begin m_brake = 1'b0; model_start(); end
    end else if (m_duty == 0) begin
      model_start();
    end else if (same) begin
      m_duty = (m_duty + STEP > tgt) ? tgt : m_duty + STEP;
    end else begin
      m_brake = 1'b1;
      m_duty  = (m_duty > STEP) ? m_duty - STEP : 0;
    end
  endtask

  task automatic model_edge();
    if (m_cnt == PER - 1) model_wrap();
    m_fault = (m_cmd == 2'b11);
    m_cmd   = {Front, Rotate};
    m_cnt   = (m_cnt == PER - 1) ? 0 : m_cnt + 1;
  endtask

  function automatic logic [7:0] exp_vec();
    bit p;
    p = (m_cnt < m_duty);
    return {2'b00, p, p, m_ldir, m_rdir, m_brake, m_fault};
  endfunction

  function automatic logic [7:0] act_vec();
    return {2'b00, LeftPwm, RightPwm, LeftDir, RightDir, Busy, Fault};
  endfunction

  task automatic tick();
    @(posedge Clock);
    if (!Reset) model_edge();
    @(negedge Clock);
    chk("cycle", act_vec(), exp_vec());
  endtask

  typedef struct {
    bit [1:0] in;
    int       hi_r;  bit [1:0] dir_r;  bit busy_r;
    int       hi_j;  bit [1:0] dir_j;  bit busy_j;
  } win_t;

  win_t tbl[19];

  initial begin
    int       hl, hr;
    bit [1:0] prev_in;
    tbl[0]  = '{2'b10, 0, 2'b11, 1'b0, 0, 2'b11, 1'b0};
    tbl[1]  = '{2'b10, 4, 2'b11, 1'b0, 8, 2'b11, 1'b0};
    tbl[2]  = '{2'b10, 8, 2'b11, 1'b0, 8, 2'b11, 1'b0};
    tbl[3]  = '{2'b01, 8, 2'b11, 1'b0, 8, 2'b11, 1'b0};
    tbl[4]  = '{2'b01, 4, 2'b11, 1'b1, 0, 2'b11, 1'b1};
    tbl[5]  = '{2'b01, 0, 2'b11, 1'b1, 4, 2'b10, 1'b0};
    tbl[6]  = '{2'b01, 4, 2'b10, 1'b0, 4, 2'b10, 1'b0};
    tbl[7]  = '{2'b10, 4, 2'b10, 1'b0, 4, 2'b10, 1'b0};
    tbl[8]  = '{2'b10, 0, 2'b10, 1'b1, 0, 2'b10, 1'b1};
    tbl[9]  = '{2'b10, 4, 2'b11, 1'b0, 8, 2'b11, 1'b0};
    tbl[10] = '{2'b11, 8, 2'b11, 1'b0, 8, 2'b11, 1'b0};
    tbl[11] = '{2'b11, 4, 2'b11, 1'b1, 0, 2'b11, 1'b1};
    tbl[12] = '{2'b11, 0, 2'b11, 1'b1, 0, 2'b11, 1'b0};
    tbl[13] = '{2'b10, 0, 2'b11, 1'b0, 0, 2'b11, 1'b0};
    tbl[14] = '{2'b10, 4, 2'b11, 1'b0, 8, 2'b11, 1'b0};
    tbl[15] = '{2'b00, 8, 2'b11, 1'b0, 8, 2'b11, 1'b0};
    tbl[16] = '{2'b00, 4, 2'b11, 1'b1, 0, 2'b11, 1'b1};
    tbl[17] = '{2'b00, 0, 2'b11, 1'b1, 0, 2'b11, 1'b0};
    tbl[18] = '{2'b00, 0, 2'b11, 1'b0, 0, 2'b11, 1'b0};

    Reset = 1'b1; Front = 1'b0; Rotate = 1'b0;
    model_reset();
    repeat (2) @(posedge Clock);
    @(negedge Clock);
    Reset = 1'b0;
    chk("reset_state", act_vec(), 8'h0C);

    // Period table: window j shows the decision taken on window j-1's command
    prev_in = 2'b00;
    for (int w = 0; w < 19; w++) begin
      {Front, Rotate} = tbl[w].in;
      hl = 0; hr = 0;
      for (int k = 0; k < PER; k++) begin
        hl += int'(LeftPwm);
        hr += int'(RightPwm);
        if (k == 1) chk($sformatf("fault_w%0d_k1", w), {7'd0, Fault}, {7'd0, prev_in == 2'b11});
        if (k == 2) chk($sformatf("fault_w%0d_k2", w), {7'd0, Fault}, {7'd0, tbl[w].in == 2'b11});
        if (k == PER - 1) begin
          chk($sformatf("dirs_w%0d", w), {6'd0, LeftDir, RightDir}, {6'd0, RAMP ? tbl[w].dir_r : tbl[w].dir_j});
          chk($sformatf("busy_w%0d", w), {7'd0, Busy}, {7'd0, RAMP ? tbl[w].busy_r : tbl[w].busy_j});
        end
        tick();
      end
      chk($sformatf("left_hi_w%0d", w), 8'(hl), 8'(RAMP ? tbl[w].hi_r : tbl[w].hi_j));
      chk($sformatf("right_hi_w%0d", w), 8'(hr), 8'(RAMP ? tbl[w].hi_r : tbl[w].hi_j));
      prev_in = tbl[w].in;
    end

    // Reset in the middle of a full-duty period must drop the PWMs before the next edge
    {Front, Rotate} = 2'b10;
    repeat (3 * PER) tick();
    for (int i = 0; i < PER && m_cnt != 5; i++) tick();
    chk("pre_reset_pwm", {6'd0, LeftPwm, RightPwm}, 8'd3);
    #1 Reset = 1'b1;
    #1;
    chk("async_reset_left", {7'd0, LeftPwm}, 8'd0);
    chk("async_reset_right", {7'd0, RightPwm}, 8'd0);
    model_reset();
    @(posedge Clock);
    @(negedge Clock);
    {Front, Rotate} = 2'b00;
    Reset = 1'b0;
    chk("after_reset", act_vec(), 8'h0C);
    repeat (2 * PER + 5) tick();

    // Random command segments against the model
    for (int s = 0; s < 40; s++) begin
      {Front, Rotate} = 2'($urandom_range(0, 3));
      repeat ($urandom_range(1, 40)) tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/motor_driver.md
# motor_driver

Actuator-side counterpart of the wall-following controller. Consumes its Front/Rotate commands and drives two wheel motors, each with a PWM enable and a direction bit. Duty is ramped, and any direction reversal passes through a brake phase at zero duty, so the H-bridges never see an instantaneous reversal. Sits between the controller outputs and the motor pins on the board.

## Interface
- PWM_PERIOD, 100, PWM period in Clock cycles (≥2)
- DUTY_MAX, 80, forward-drive duty in cycles (≤ PWM_PERIOD)
- ROT_DUTY, 50, rotation duty in cycles (≤ PWM_PERIOD)
- RAMP_STEP, 5, duty change per PWM period (≥1)
- Clock  in  1  single clock, all logic on posedge
- Reset  in  1  asynchronous, active-high
- Front  in  1  drive-forward command from the controller
- Rotate  in  1  rotate-in-place command from the controller
- LeftPwm  out  1  left wheel enable
- RightPwm  out  1  right wheel enable
- LeftDir  out  1  left wheel direction, 1 = forward
- RightDir  out  1  right wheel direction, 1 = forward
- Busy  out  1  high while in the brake state
- Fault  out  1  high while Front and Rotate are both asserted

## Operation
- Front and Rotate are registered once on posedge before use. The decoded command is:
  - 10 = FWD
  - 01 = ROT
  - 00 = STOP
  - 11 = STOP, and Fault is driven high in the cycle after it is sampled.
- Command targets:
  - FWD: dirs (1,1), duty DUTY_MAX.
  - ROT: dirs (1,0), duty ROT_DUTY. This is a right turn, away from the followed left wall.
  - STOP: duty 0, dirs held at their last value.
- Free-running counter `cnt` counts 0..PWM_PERIOD-1, then wraps. "Wrap" means the cycle in which cnt == PWM_PERIOD-1.
- PWM outputs are registered: XPwm <= (cnt_next < duty). Both wheels share one duty value.
- State, duty and dirs update only at wrap, so the PWM never glitches mid-period.
- States:
  - PARADO (duty 0):
    - FWD → ANDANDO, dirs (1,1), duty = min(RAMP_STEP, DUTY_MAX).
    - ROT → GIRANDO, dirs (1,0), duty = min(RAMP_STEP, ROT_DUTY).
    - STOP → stay.
  - ANDANDO:
    - FWD → duty = min(duty+RAMP_STEP, DUTY_MAX).
    - ROT or STOP → FREANDO.
  - GIRANDO:
    - ROT → duty moves toward ROT_DUTY by RAMP_STEP, clamped at the target.
    - FWD or STOP → FREANDO.
  - FREANDO (Busy = 1):
    - If duty > 0: duty = (duty ≤ RAMP_STEP) ? 0 : duty − RAMP_STEP.
    - If duty == 0: enter the state for the *current* command, as from PARADO, including its first ramp step. STOP → PARADO.
- The command is re-evaluated at every wrap. A command flipping back during FREANDO does not abort the brake; duty must reach 0 first.
- Duty arithmetic is width $clog2(PWM_PERIOD+1). Add and subtract saturate; no wrap-around.

## Timing
- Reset values: cnt = 0, duty = 0, state PARADO, LeftPwm = RightPwm = 0, LeftDir = RightDir = 1, Busy = 0, Fault = 0.
- Reset asserted mid-operation forces the PWMs to 0 immediately (asynchronous), with no brake phase.
- Command latency:
  - One cycle for the input register.
  - Up to PWM_PERIOD cycles to the next wrap.
  - One further cycle to the PWM output register.
- Dir changes are registered at the same wrap edge as the duty change. A reversal always has at least one full period at duty 0 before it.

## Configuration
- MOTOR_DRIVER_RAMP_EN defined:
  - Ramping as specified above.
- MOTOR_DRIVER_RAMP_EN undefined:
  - RAMP_STEP is ignored. At each wrap, duty jumps straight to the target.
  - FREANDO still holds exactly one period at duty 0 before switching direction.
  - STOP from ANDANDO or GIRANDO still passes through FREANDO.

## Structure
- Package motor_pkg holds:
  - the state enum (PARADO, ANDANDO, GIRANDO, FREANDO);
  - command decode constants;
  - DIR_FWD = 1 and DIR_REV = 0.
- Sub-module motor_pwm_channel compares the shared cnt against duty and registers the PWM output. It is instantiated twice, once per wheel.
- The counter, FSM and duty ramp live in the top level.

## Test plan
Bench parameters: PWM_PERIOD = 10, DUTY_MAX = 8, ROT_DUTY = 4, RAMP_STEP = 4, ramp enabled.

- Reset, then Front=1 → after the first wrap both PWMs are high 4 of 10 cycles with dirs (1,1); from the second wrap on, 8 of 10.
- Steady FWD, then Rotate=1 with Front=0:
  - Busy rises at the next wrap and duty steps 8 → 4 → 0.
  - At the following wrap, dirs become (1,0) and duty is 4. Busy is low from that wrap.
- ROT, then FWD → one 4 → 0 brake period, then dirs (1,1) and duty 4 → 8. RightDir never changes while duty > 0.
- Front=Rotate=1 during FWD → Fault = 1 one cycle later and the block brakes to PARADO. Fault clears one cycle after the inputs return to 10, and ramp-up restarts.
- Reset asserted at cnt = 5 with duty 8 → PWMs low in the same cycle. After release, outputs hold the reset values until a command arrives.
- Ramp disabled, FWD to ROT → duty goes 8, then exactly one period at 0, then 4.
